fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the multicycle MIPS datapath, directly downstream of the control unit. It owns the PC register and the instruction register. It executes the control unit's `Load_PC`, `Empty_PC` and `IRWrite` commands against a handshaked instruction memory, and exposes the decoded instruction fields to the control unit and the register file. A fetch-completion pulse lets the control unit sequence its own states on real memory latency instead of fixed cycle counts.

## Interface
Parameters:
- `ADDR_W`, 32: PC and memory address width.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: PC value after reset or `Empty_PC`.
- `MEM_TIMEOUT`, 15: maximum number of cycles spent waiting in WAIT before an error is raised. Range 1..255.

Ports:
- `Clk`, in, 1: single clock, rising edge.
- `Reset_PC`, in, 1: reset, synchronous, active-low.
- `Load_PC`, in, 1: load `PC_in` into the PC.
- `Empty_PC`, in, 1: clear the PC to `RESET_PC` and abort any fetch.
- `PC_in`, in, `ADDR_W`: next-PC value from the ALU.
- `IRWrite`, in, 1: start a fetch at the current PC and capture the result into IR.
- `Mem_addr`, out, `ADDR_W`: instruction memory address (always equals PC).
- `Mem_rd`, out, 1: read request, held until acknowledged.
- `Mem_rdata`, in, `DATA_W`: read data, valid when `Mem_ack` is high.
- `Mem_ack`, in, 1: read acknowledge.
- `PC`, out, `ADDR_W`: current PC.
- `IR`, out, `DATA_W`: current instruction.
- `Opcode`, out, 6: `IR[31:26]`.
- `Rs`, out, 5: `IR[25:21]`.
- `Rt`, out, 5: `IR[20:16]`.
- `Rd`, out, 5: `IR[15:11]`.
- `Funct`, out, 6: `IR[5:0]`.
- `Imm16`, out, 16: `IR[15:0]`.
- `Fetch_busy`, out, 1: high in WAIT.
- `Fetch_done`, out, 1: one-cycle pulse in DONE.
- `Fetch_err`, out, 1: sticky memory-timeout flag.

## Operation
- **FSM states:** IDLE, WAIT, DONE, ERR.
- **IDLE:** `IRWrite` moves the FSM to WAIT.
- **WAIT:**
  - `Mem_rd` is high and the PC is frozen.
  - `Mem_ack` causes `IR <= Mem_rdata` and moves the FSM to DONE.
- **DONE:** `Fetch_done` is high for one cycle, then the FSM returns to IDLE.
- **ERR:**
  - Entered when the wait counter reaches `MEM_TIMEOUT` with no ack.
  - On entry, `IR <= 32'h0000_0000` (NOP) and `Fetch_err` is set.
  - The FSM stays in ERR until `Empty_PC` or reset.
- **`IRWrite` outside IDLE** is ignored.
- **`Mem_ack` outside WAIT** is ignored.
- **PC write priority:** `Empty_PC` > live `Load_PC` > pending load.
- **`Empty_PC`, any state:**
  - PC <= `RESET_PC` and the FSM goes to IDLE.
  - The pending load and `Fetch_err` are cleared; IR is kept.
- **`Load_PC` in IDLE, DONE or ERR:** PC <= `{PC_in[ADDR_W-1:2], 2'b00}`, so the low two bits are always forced to zero.
- **`Load_PC` in WAIT:**
  - The value is stored as a pending load (`pend_valid`, `pend_pc`).
  - A later `Load_PC` in the same WAIT overwrites it.
  - The pending value is applied on the DONE cycle edge unless a live `Load_PC` arrives in DONE, in which case the live value wins.
  - A pending load left in ERR is discarded by `Empty_PC`.
- **Decode fields** are purely combinational from IR.

## Timing
- **Reset values:**
  - `PC` = `RESET_PC`, `IR` = 0, state IDLE.
  - `Mem_rd`, `Fetch_busy`, `Fetch_done`, `Fetch_err` = 0.
  - Pending load cleared.
- **Fetch timing:**
  - `IRWrite` at cycle N gives `Mem_rd` = 1 from cycle N+1.
  - `Mem_ack` at cycle M ≥ N+1 gives the new IR and `Fetch_done` = 1 at M+1, and IDLE at M+2.
  - Minimum latency from `IRWrite` to `Fetch_done` is 2 cycles.
- **Back-to-back fetches:** `IRWrite` issued in the DONE cycle is dropped. The earliest accepted follow-up is in the next IDLE cycle.
- **PC load timing:** a PC load is visible on `PC`/`Mem_addr` the cycle after the command.
- **Timeout:**
  - The wait counter resets on entering WAIT.
  - ERR is entered after `MEM_TIMEOUT` consecutive WAIT cycles without ack.
  - An ack on the final WAIT cycle counts as success.
- **Reset mid-fetch:** a reset during WAIT drops `Mem_rd` on the next cycle. Any later ack is ignored.

## Configuration
- Macro `FETCH_TIMEOUT_EN`.
- **Defined:** the wait counter, ERR state and `Fetch_err` are built as described above.
- **Undefined:**
  - WAIT waits indefinitely.
  - `Fetch_err` is tied to 0 and ERR is unreachable.
  - `MEM_TIMEOUT` is unused.

## Structure
- **Shared package `mips_pkg`:**
  - `fetch_state_t` enum.
  - `NOP_INSTR` constant.
  - Field position constants: `OPCODE_MSB`/`LSB`, `RS_`/`RT_`/`RD_` ranges, `FUNCT` range.
- **Sub-module `ir_decode`:** combinational split of IR into `Opcode`/`Rs`/`Rt`/`Rd`/`Funct`/`Imm16`. It is reused by later stages.

## Test plan
- Reset, then `IRWrite` with ack after 3 cycles and `Mem_rdata` = 32'h2008_0005 → `Mem_rd` high for 3 cycles, `IR` = 32'h2008_0005, `Opcode` = 6'h08, `Rt` = 8, `Imm16` = 5, one `Fetch_done` pulse, `Mem_addr` = 0 throughout.
- `Load_PC` in IDLE with `PC_in` = 32'h0000_0047 → `PC` = 32'h0000_0044 the next cycle.
- `Load_PC` = 32'h10 then 32'h20 during WAIT, ack → `Mem_addr` stays at the old PC during WAIT, and `PC` = 32'h20 after DONE. The same test with a live `Load_PC` = 32'h30 in DONE gives `PC` = 32'h30.
- With `FETCH_TIMEOUT_EN` defined and `MEM_TIMEOUT` = 4, `IRWrite` with no ack → ERR after 4 WAIT cycles, `Fetch_err` = 1, `IR` = 0. A later `IRWrite` is ignored. `Empty_PC` then gives IDLE, `Fetch_err` = 0, `PC` = `RESET_PC`.
- `Reset_PC` low in the second WAIT cycle, then a late ack → `Mem_rd` = 0, `IR` = 0 and `PC` = `RESET_PC` on the cycle after reset, and the late ack does not change `IR`.
- `Empty_PC` and `Load_PC` asserted together → `PC` = `RESET_PC`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, NOP encoding and instruction field positions.
package mips_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_DONE = 2'd2,
        F_ERR  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

endpackage

// File: rtl/ir_decode.sv
// Combinational split of a 32-bit MIPS instruction into its fields.
module ir_decode
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] imm16
);

    assign opcode = ir[OPCODE_MSB:OPCODE_LSB];
    assign rs     = ir[RS_MSB:RS_LSB];
    assign rt     = ir[RT_MSB:RT_LSB];
    assign rd     = ir[RD_MSB:RD_LSB];
    assign funct  = ir[FUNCT_MSB:FUNCT_LSB];
    assign imm16  = ir[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR and handshaked memory read FSM.
// Optional memory timeout (ERR state, Fetch_err) built when FETCH_TIMEOUT_EN is defined.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              MEM_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset_PC,
    input  logic              Load_PC,
    input  logic              Empty_PC,
    input  logic [ADDR_W-1:0] PC_in,
    input  logic              IRWrite,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic              Mem_rd,
    input  logic [DATA_W-1:0] Mem_rdata,
    input  logic              Mem_ack,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic [5:0]        Opcode,
    output logic [4:0]        Rs,
    output logic [4:0]        Rt,
    output logic [4:0]        Rd,
    output logic [5:0]        Funct,
    output logic [15:0]       Imm16,
    output logic              Fetch_busy,
    output logic              Fetch_done,
    output logic              Fetch_err
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pend_pc, pc_in_al;
    logic [DATA_W-1:0] ir;
    logic              pend_valid;
    logic              timeout;

    assign pc_in_al = {PC_in[ADDR_W-1:2], 2'b00};

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
    logic [7:0] wait_cnt;
    logic       err;

    // Counter sits at zero outside WAIT, so it is fresh on every WAIT entry.
    always_ff @(posedge Clk) begin
        if (!Reset_PC || state != F_WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 8'd1;
    end

    assign timeout = (state == F_WAIT) && !Mem_ack && (wait_cnt == TO_LAST);

    always_ff @(posedge Clk) begin
        if (!Reset_PC || Empty_PC)
            err <= 1'b0;
        else if (timeout)
            err <= 1'b1;
    end

    assign Fetch_err = err;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(MEM_TIMEOUT);
    assign timeout   = 1'b0;
    assign Fetch_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            F_IDLE: if (IRWrite) state_n = F_WAIT;
            F_WAIT: begin
                if (Mem_ack)      state_n = F_DONE;
                else if (timeout) state_n = F_ERR;
            end
            F_DONE: state_n = F_IDLE;
            F_ERR:  state_n = F_ERR;
            default: state_n = F_IDLE;
        endcase
        if (Empty_PC) state_n = F_IDLE;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_PC) begin
            state      <= F_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            state <= state_n;

            // PC priority: Empty_PC, then a live load, then the load deferred from WAIT.
            if (Empty_PC) begin
                pc         <= RESET_PC;
                pend_valid <= 1'b0;
            end else if (Load_PC && state == F_WAIT) begin
                pend_valid <= 1'b1;
                pend_pc    <= pc_in_al;
            end else if (Load_PC) begin
                pc <= pc_in_al;
                if (state == F_DONE) pend_valid <= 1'b0;
            end else if (state == F_DONE && pend_valid) begin
                pc         <= pend_pc;
                pend_valid <= 1'b0;
            end

            // An Empty_PC in the ack cycle aborts the fetch without touching IR.
            if (!Empty_PC && state == F_WAIT) begin
                if (Mem_ack)      ir <= Mem_rdata;
                else if (timeout) ir <= DATA_W'(NOP_INSTR);
            end
        end
    end

    assign PC         = pc;
    assign Mem_addr   = pc;
    assign IR         = ir;
    assign Mem_rd     = (state == F_WAIT);
    assign Fetch_busy = (state == F_WAIT);
    assign Fetch_done = (state == F_DONE);

    ir_decode u_dec (
        .ir     (ir[31:0]),
        .opcode (Opcode),
        .rs     (Rs),
        .rt     (Rt),
        .rd     (Rd),
        .funct  (Funct),
        .imm16  (Imm16)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch results are queued at issue and checked on Fetch_done.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset_PC = 1'b0;
    logic        Load_PC = 1'b0;
    logic        Empty_PC = 1'b0;
    logic [31:0] PC_in = '0;
    logic        IRWrite = 1'b0;
    logic [31:0] Mem_addr;
    logic        Mem_rd;
    logic [31:0] Mem_rdata = '0;
    logic        Mem_ack = 1'b0;
    logic [31:0] PC;
    logic [31:0] IR;
    logic [5:0]  Opcode;
    logic [4:0]  Rs, Rt, Rd;
    logic [5:0]  Funct;
    logic [15:0] Imm16;
    logic        Fetch_busy, Fetch_done, Fetch_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ir;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fn;
        logic [15:0] imm;
    } exp_t;

    exp_t sb[$];

    always #5 Clk = ~Clk;

    fetch_unit #(
        .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .MEM_TIMEOUT(4)
    ) dut (
        .Clk(Clk), .Reset_PC(Reset_PC), .Load_PC(Load_PC), .Empty_PC(Empty_PC),
        .PC_in(PC_in), .IRWrite(IRWrite), .Mem_addr(Mem_addr), .Mem_rd(Mem_rd),
        .Mem_rdata(Mem_rdata), .Mem_ack(Mem_ack), .PC(PC), .IR(IR),
        .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Funct(Funct), .Imm16(Imm16),
        .Fetch_busy(Fetch_busy), .Fetch_done(Fetch_done), .Fetch_err(Fetch_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] ir, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn,
                                input logic [15:0] imm);
        exp_t e;
        e.ir = ir; e.op = op; e.rs = rs; e.rt = rt; e.rd = rd; e.fn = fn; e.imm = imm;
        sb.push_back(e);
    endtask

    // Monitor: every Fetch_done cycle must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (Fetch_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got Fetch_done=1 IR=%h expected no pulse", IR);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ir", IR, e.ir);
                chk("sb_opcode", 32'(Opcode), 32'(e.op));
                chk("sb_rs", 32'(Rs), 32'(e.rs));
                chk("sb_rt", 32'(Rt), 32'(e.rt));
                chk("sb_rd", 32'(Rd), 32'(e.rd));
                chk("sb_funct", 32'(Funct), 32'(e.fn));
                chk("sb_imm16", 32'(Imm16), 32'(e.imm));
            end
        end
    end

    // Plain fetch at address pc_exp; ack arrives in WAIT cycle number wait_cycles.
    task automatic fetch(input logic [31:0] data, input logic [31:0] pc_exp, input int wait_cycles);
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        for (int i = 1; i < wait_cycles; i++) begin
            chk("wait_mem_rd", 32'(Mem_rd), 32'd1);
            chk("wait_addr", Mem_addr, pc_exp);
            tick();
        end
        chk("ack_mem_rd", 32'(Mem_rd), 32'd1);
        chk("ack_addr", Mem_addr, pc_exp);
        Mem_ack = 1'b1;
        Mem_rdata = data;
        tick();
        Mem_ack = 1'b0;
        Mem_rdata = 32'hFFFF_FFFF;
        chk("done_mem_rd", 32'(Mem_rd), 32'd0);
        tick();
        chk("idle_busy", 32'(Fetch_busy), 32'd0);
    endtask

    // Fetch with two pending loads in WAIT; optional live load and a dropped IRWrite in DONE.
    task automatic fetch_loads(input logic [31:0] data, input logic [31:0] pc_exp,
                               input bit live, input logic [31:0] pc_final);
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        Load_PC = 1'b1; PC_in = 32'h10;
        tick();
        PC_in = 32'h20;
        tick();
        Load_PC = 1'b0;
        chk("pend_addr_frozen", Mem_addr, pc_exp);
        Mem_ack = 1'b1; Mem_rdata = data;
        tick();
        Mem_ack = 1'b0;
        chk("done_pc_old", PC, pc_exp);
        IRWrite = 1'b1;
        if (live) begin
            Load_PC = 1'b1; PC_in = 32'h30;
        end
        tick();
        IRWrite = 1'b0; Load_PC = 1'b0;
        chk("pend_pc_after_done", PC, pc_final);
        chk("irwrite_in_done_dropped", 32'(Fetch_busy), 32'd0);
    endtask

    initial begin
        repeat (2) tick();
        Reset_PC = 1'b1;
        chk("rst_pc", PC, 32'h0);
        chk("rst_ir", IR, 32'h0);
        chk("rst_mem_rd", 32'(Mem_rd), 32'd0);
        chk("rst_busy", 32'(Fetch_busy), 32'd0);
        chk("rst_done", 32'(Fetch_done), 32'd0);
        chk("rst_err", 32'(Fetch_err), 32'd0);

        // addi $t0,$zero,5 with ack in the 3rd WAIT cycle
        expect_fetch(32'h2008_0005, 6'h08, 5'd0, 5'd8, 5'd0, 6'h05, 16'h0005);
        fetch(32'h2008_0005, 32'h0, 3);

        Load_PC = 1'b1; PC_in = 32'h0000_0047;
        tick();
        Load_PC = 1'b0;
        chk("load_align_pc", PC, 32'h44);
        chk("load_align_addr", Mem_addr, 32'h44);

        // add $8,$9,$10 at minimum latency
        expect_fetch(32'h012A_4020, 6'h00, 5'd9, 5'd10, 5'd8, 6'h20, 16'h4020);
        fetch(32'h012A_4020, 32'h44, 1);

        expect_fetch(32'h8C82_0004, 6'h23, 5'd4, 5'd2, 5'd0, 6'h04, 16'h0004);
        fetch_loads(32'h8C82_0004, 32'h44, 1'b0, 32'h20);
        expect_fetch(32'h2008_0005, 6'h08, 5'd0, 5'd8, 5'd0, 6'h05, 16'h0005);
        fetch_loads(32'h2008_0005, 32'h20, 1'b1, 32'h30);

        // Ack outside WAIT is ignored
        Mem_ack = 1'b1; Mem_rdata = 32'h1234_5678;
        tick();
        Mem_ack = 1'b0;
        chk("stray_ack_ir", IR, 32'h2008_0005);

`ifdef FETCH_TIMEOUT_EN
        // Ack on the final allowed WAIT cycle still succeeds
        expect_fetch(32'h012A_4020, 6'h00, 5'd9, 5'd10, 5'd8, 6'h20, 16'h4020);
        fetch(32'h012A_4020, 32'h30, 4);
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_busy", 32'(Fetch_busy), 32'd1);
            tick();
        end
        chk("to_err", 32'(Fetch_err), 32'd1);
        chk("to_ir_nop", IR, 32'h0);
        chk("to_busy_off", 32'(Fetch_busy), 32'd0);
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        chk("err_irwrite_ignored", 32'(Fetch_busy), 32'd0);
        chk("err_sticky", 32'(Fetch_err), 32'd1);
        Empty_PC = 1'b1;
        tick();
        Empty_PC = 1'b0;
        chk("empty_err_clr", 32'(Fetch_err), 32'd0);
        chk("empty_pc", PC, 32'h0);
        expect_fetch(32'h8C82_0004, 6'h23, 5'd4, 5'd2, 5'd0, 6'h04, 16'h0004);
        fetch(32'h8C82_0004, 32'h0, 2);
`endif

        Load_PC = 1'b1; Empty_PC = 1'b1; PC_in = 32'h80;
        tick();
        Load_PC = 1'b0; Empty_PC = 1'b0;
        chk("empty_beats_load", PC, 32'h0);

        // Reset asserted during the second WAIT cycle, then a late ack
        Load_PC = 1'b1; PC_in = 32'h100;
        tick();
        Load_PC = 1'b0;
        IRWrite = 1'b1;
        tick();
        IRWrite = 1'b0;
        tick();
        Reset_PC = 1'b0;
        tick();
        Reset_PC = 1'b1;
        chk("midrst_mem_rd", 32'(Mem_rd), 32'd0);
        chk("midrst_ir", IR, 32'h0);
        chk("midrst_pc", PC, 32'h0);
        Mem_ack = 1'b1; Mem_rdata = 32'hDEAD_BEEF;
        tick();
        Mem_ack = 1'b0;
        tick();
        chk("late_ack_ir", IR, 32'h0);

        repeat (2) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
